// File: rtl/control_programacion.sv
// control_programacion: key-driven editor for hour/date/chronometer fields with
// cursor blink and RTC write handshake. Optional 12 h mode: define FORMATO12_EN.
module control_programacion #(
    parameter logic [23:0] BLINK_DIV = 24'd12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_enter,
    input  logic       btn_der,
    input  logic       btn_izq,
    input  logic       btn_arriba,
    input  logic       btn_abajo,
    input  logic [7:0] Hora,
    input  logic [7:0] min,
    input  logic [7:0] seg,
    input  logic [7:0] dia,
    input  logic [7:0] mes,
    input  logic [7:0] year,
    input  logic [7:0] hcrono,
    input  logic [7:0] mcrono,
    input  logic [7:0] scrono,
    input  logic       wr_ack,
    output logic [7:0] progra_dir,
    output logic [2:0] dir_cursor,
    output logic       clk_alarm,
    output logic [7:0] edit_a,
    output logic [7:0] edit_b,
    output logic [7:0] edit_c,
    output logic       wr_req,
    output logic [7:0] wr_dir,
    output logic       hformato,
    output logic       am_pm
);
    typedef enum logic [2:0] {IDLE, PROG_HORA, PROG_FECHA, PROG_CRONO, WRITE} state_t;

    state_t      r_state;
    logic [23:0] r_cnt;

    logic       w_h12;
    logic [2:0] w_cm1;
    logic [1:0] w_sel;
    logic [7:0] w_cur;
    logic [6:0] w_bin, w_step, w_min, w_max, w_sum, w_inc, w_dec;
    logic       w_wrap_up, w_wrap_dn, w_wrap;
    logic [7:0] w_new;
    logic       w_any;

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [6:0] t;
        t = v / 7'd10;
        return {t[3:0], 4'(v - t * 7'd10)};
    endfunction

`ifdef FORMATO12_EN
    assign w_h12 = hformato;
`else
    assign w_h12 = 1'b0;
`endif

    // Cursor 1-2 edits field a, 3-4 field b, 5-6 field c; odd digit is the tens digit
    assign w_cm1  = dir_cursor - 3'd1;
    assign w_sel  = w_cm1[2:1];
    assign w_step = dir_cursor[0] ? 7'd10 : 7'd1;
    assign w_cur  = w_sel == 2'd0 ? edit_a : w_sel == 2'd1 ? edit_b : edit_c;
    assign w_bin  = 7'(w_cur[7:4]) * 7'd10 + 7'(w_cur[3:0]);
    assign w_any  = btn_mode | btn_enter | btn_der | btn_izq | btn_arriba | btn_abajo;

    // Range of the field under the cursor, depending on which screen is being edited
    always_comb begin
        w_min = 7'd0;
        w_max = 7'd59;
        if (w_sel == 2'd0) begin
            w_min = (r_state == PROG_FECHA || (r_state == PROG_HORA && w_h12)) ? 7'd1 : 7'd0;
            w_max = r_state == PROG_FECHA ? 7'd31 : (r_state == PROG_HORA && w_h12) ? 7'd12 : 7'd23;
        end else if (r_state == PROG_FECHA) begin
            w_min = w_sel == 2'd1 ? 7'd1 : 7'd0;
            w_max = w_sel == 2'd1 ? 7'd12 : 7'd99;
        end
    end

    // Saturating-wrap arithmetic: overshoot lands on the opposite limit, not modulo
    assign w_sum     = w_bin + w_step;
    assign w_wrap_up = w_sum > w_max;
    assign w_wrap_dn = w_bin < w_min + w_step;
    assign w_inc     = w_wrap_up ? w_min : w_sum;
    assign w_dec     = w_wrap_dn ? w_max : w_bin - w_step;
    assign w_new     = to_bcd(btn_arriba ? w_inc : w_dec);
    assign w_wrap    = btn_arriba ? w_wrap_up : w_wrap_dn;

    // Editor FSM with all outputs registered; one key acts per cycle by priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            progra_dir <= 8'h00;
            dir_cursor <= 3'd0;
            clk_alarm  <= 1'b1;
            edit_a     <= 8'h00;
            edit_b     <= 8'h00;
            edit_c     <= 8'h00;
            wr_req     <= 1'b0;
            wr_dir     <= 8'h00;
            hformato   <= 1'b0;
            am_pm      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt     <= '0;
                    clk_alarm <= 1'b1;
`ifdef FORMATO12_EN
                    if (btn_mode && btn_enter) begin
                        hformato <= ~hformato;
                    end else
`endif
                    if (btn_mode) begin
                        r_state    <= PROG_HORA;
                        edit_a     <= Hora;
                        edit_b     <= min;
                        edit_c     <= seg;
                        progra_dir <= 8'h05;
                        dir_cursor <= 3'd1;
                    end
                end
                PROG_HORA, PROG_FECHA, PROG_CRONO: begin
                    if (w_any) begin
                        r_cnt     <= '0;
                        clk_alarm <= 1'b1;
                    end else if (r_cnt == BLINK_DIV - 24'd1) begin
                        r_cnt     <= '0;
                        clk_alarm <= ~clk_alarm;
                    end else begin
                        r_cnt <= r_cnt + 24'd1;
                    end
                    if (btn_mode) begin
                        dir_cursor <= 3'd1;
                        if (r_state == PROG_HORA) begin
                            r_state    <= PROG_FECHA;
                            edit_a     <= dia;
                            edit_b     <= mes;
                            edit_c     <= year;
                            progra_dir <= 8'h06;
                        end else if (r_state == PROG_FECHA) begin
                            r_state    <= PROG_CRONO;
                            edit_a     <= hcrono;
                            edit_b     <= mcrono;
                            edit_c     <= scrono;
                            progra_dir <= 8'h04;
                        end else begin
                            r_state    <= IDLE;
                            progra_dir <= 8'h00;
                            dir_cursor <= 3'd0;
                        end
                    end else if (btn_enter) begin
                        r_state <= WRITE;
                        wr_req  <= 1'b1;
                        wr_dir  <= progra_dir;
                    end else if (btn_der) begin
                        dir_cursor <= dir_cursor == 3'd6 ? 3'd1 : dir_cursor + 3'd1;
                    end else if (btn_izq) begin
                        dir_cursor <= dir_cursor == 3'd1 ? 3'd6 : dir_cursor - 3'd1;
                    end else if (btn_arriba || btn_abajo) begin
                        if (w_sel == 2'd0) edit_a <= w_new;
                        else if (w_sel == 2'd1) edit_b <= w_new;
                        else edit_c <= w_new;
`ifdef FORMATO12_EN
                        if (r_state == PROG_HORA && w_sel == 2'd0 && hformato && w_wrap)
                            am_pm <= ~am_pm;
`endif
                    end
                end
                default: begin
                    r_cnt     <= '0;
                    clk_alarm <= 1'b1;
                    if (wr_ack) begin
                        r_state    <= IDLE;
                        wr_req     <= 1'b0;
                        progra_dir <= 8'h00;
                        dir_cursor <= 3'd0;
                    end
                end
            endcase
        end
    end

`ifndef FORMATO12_EN
    logic w_unused;
    assign w_unused = w_wrap;
`endif
endmodule

// File: tb/tb_control_programacion.sv
// tb_control_programacion: directed stimulus with a scoreboard queue and negedge monitor.
module tb_control_programacion;
    localparam logic [5:0] K_MODE = 6'b100000, K_ENT = 6'b010000, K_DER = 6'b001000,
                           K_IZQ = 6'b000100, K_ARR = 6'b000010, K_ABA = 6'b000001;
    localparam logic [3:0] P_DIR = 0, CUR = 1, ALM = 2, EA = 3, EB = 4, EC = 5,
                           WRQ = 6, WRD = 7, HF = 8, AP = 9;

    typedef struct packed {
        logic [3:0] id;
        logic [7:0] val;
    } exp_t;

    logic clk = 0, rst;
    logic btn_mode = 0, btn_enter = 0, btn_der = 0, btn_izq = 0, btn_arriba = 0, btn_abajo = 0;
    logic [7:0] Hora, min, seg, dia, mes, year, hcrono, mcrono, scrono;
    logic wr_ack = 0;
    logic [7:0] progra_dir, edit_a, edit_b, edit_c, wr_dir;
    logic [2:0] dir_cursor;
    logic clk_alarm, wr_req, hformato, am_pm;

    exp_t q[$];
    int n_checks = 0, n_fail = 0;

    control_programacion #(.BLINK_DIV(24'd4)) dut (
        .clk(clk), .rst(rst),
        .btn_mode(btn_mode), .btn_enter(btn_enter), .btn_der(btn_der),
        .btn_izq(btn_izq), .btn_arriba(btn_arriba), .btn_abajo(btn_abajo),
        .Hora(Hora), .min(min), .seg(seg), .dia(dia), .mes(mes), .year(year),
        .hcrono(hcrono), .mcrono(mcrono), .scrono(scrono), .wr_ack(wr_ack),
        .progra_dir(progra_dir), .dir_cursor(dir_cursor), .clk_alarm(clk_alarm),
        .edit_a(edit_a), .edit_b(edit_b), .edit_c(edit_c),
        .wr_req(wr_req), .wr_dir(wr_dir), .hformato(hformato), .am_pm(am_pm)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] act(input logic [3:0] id);
        case (id)
            P_DIR:   return progra_dir;
            CUR:     return {5'b0, dir_cursor};
            ALM:     return {7'b0, clk_alarm};
            EA:      return edit_a;
            EB:      return edit_b;
            EC:      return edit_c;
            WRQ:     return {7'b0, wr_req};
            WRD:     return wr_dir;
            HF:      return {7'b0, hformato};
            default: return {7'b0, am_pm};
        endcase
    endfunction

    function automatic string nm(input logic [3:0] id);
        case (id)
            P_DIR:   return "progra_dir";
            CUR:     return "dir_cursor";
            ALM:     return "clk_alarm";
            EA:      return "edit_a";
            EB:      return "edit_b";
            EC:      return "edit_c";
            WRQ:     return "wr_req";
            WRD:     return "wr_dir";
            HF:      return "hformato";
            default: return "am_pm";
        endcase
    endfunction

    task automatic ex(input logic [3:0] id, input logic [7:0] val);
        exp_t e;
        e.id  = id;
        e.val = val;
        q.push_back(e);
    endtask

    task automatic press(input logic [5:0] k);
        @(negedge clk);
        {btn_mode, btn_enter, btn_der, btn_izq, btn_arriba, btn_abajo} = k;
        @(posedge clk);
        #1;
        {btn_mode, btn_enter, btn_der, btn_izq, btn_arriba, btn_abajo} = 6'b0;
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        wr_ack = 1;
        @(posedge clk);
        #1;
        wr_ack = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        while (q.size() != 0) begin
            e = q.pop_front();
            n_checks++;
            if (act(e.id) !== e.val) begin
                n_fail++;
                $display("FAIL %s actual=%h expected=%h t=%0t", nm(e.id), act(e.id), e.val, $time);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1;
        Hora = 8'h23; min = 8'h55; seg = 8'h30;
        dia = 8'h01; mes = 8'h12; year = 8'h24;
        hcrono = 8'h00; mcrono = 8'h05; scrono = 8'h59;
        repeat (2) @(posedge clk);
        #1;
        ex(P_DIR, 8'h00); ex(CUR, 0); ex(ALM, 1); ex(EA, 0); ex(EB, 0); ex(EC, 0);
        ex(WRQ, 0); ex(WRD, 0); ex(HF, 0); ex(AP, 0);
        @(negedge clk);
        rst = 0;

        press(K_MODE);
        n_checks++;
        if (progra_dir !== 8'h05 || edit_a !== 8'h23 || dir_cursor !== 3'd1) begin
            n_fail++;
            $display("FAIL mode entry progra_dir=%h edit_a=%h dir_cursor=%0d", progra_dir, edit_a, dir_cursor);
        end
        ex(P_DIR, 8'h05); ex(CUR, 1); ex(EA, 8'h23); ex(EB, 8'h55); ex(EC, 8'h30); ex(ALM, 1);
        press(K_ARR);
        n_checks++;
        if (edit_a !== 8'h00) begin
            n_fail++;
            $display("FAIL hour wrap edit_a=%h", edit_a);
        end
        ex(EA, 8'h00); ex(AP, 0); ex(HF, 0);
        press(K_DER);
        ex(CUR, 2);
        press(K_DER);
        ex(CUR, 3);
        press(K_ARR);
        ex(EB, 8'h00);
        press(K_ABA);
        ex(EB, 8'h59);
        press(K_IZQ);
        press(K_IZQ);
        ex(CUR, 1);
        press(K_IZQ);
        ex(CUR, 6);
        press(K_DER);
        ex(CUR, 1);
        press(K_DER | K_ARR);
        ex(CUR, 2); ex(EA, 8'h00);

        press(K_MODE);
        ex(P_DIR, 8'h06); ex(CUR, 1); ex(EA, 8'h01); ex(EB, 8'h12); ex(EC, 8'h24);
        press(K_DER);
        press(K_ABA);
        n_checks++;
        if (edit_a !== 8'h31) begin
            n_fail++;
            $display("FAIL dia wrap edit_a=%h", edit_a);
        end
        ex(EA, 8'h31);
        press(K_DER);
        press(K_DER);
        press(K_ARR);
        ex(EB, 8'h01);
        press(K_ENT);
        n_checks++;
        if (wr_req !== 1'b1 || wr_dir !== 8'h06) begin
            n_fail++;
            $display("FAIL enter wr_req=%b wr_dir=%h", wr_req, wr_dir);
        end
        ex(WRQ, 1); ex(WRD, 8'h06); ex(EA, 8'h31); ex(EB, 8'h01); ex(EC, 8'h24);

        for (int i = 0; i < 20; i++) begin
            press(K_MODE >> (i % 6));
            ex(WRQ, 1); ex(P_DIR, 8'h06); ex(CUR, 4); ex(EA, 8'h31); ex(EB, 8'h01); ex(ALM, 1);
        end
        ack_pulse();
        n_checks++;
        if (wr_req !== 1'b0 || progra_dir !== 8'h00) begin
            n_fail++;
            $display("FAIL ack wr_req=%b progra_dir=%h", wr_req, progra_dir);
        end
        ex(WRQ, 0); ex(P_DIR, 8'h00); ex(CUR, 0); ex(EA, 8'h31);

        press(K_DER);
        press(K_ARR);
        press(K_ENT);
        ex(CUR, 0); ex(P_DIR, 8'h00); ex(WRQ, 0); ex(EA, 8'h31); ex(ALM, 1);

        press(K_MODE);
        press(K_MODE);
        press(K_MODE);
        ex(P_DIR, 8'h04); ex(CUR, 1); ex(EA, 8'h00); ex(EB, 8'h05); ex(EC, 8'h59);
        press(K_ABA);
        ex(EA, 8'h23); ex(ALM, 1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            ex(ALM, 8'(k < 4));
        end
        press(K_DER);
        ex(ALM, 1); ex(CUR, 2);
        for (int k = 1; k <= 8; k++) begin
            tick();
            ex(ALM, 8'(k < 4 || k >= 8));
        end
        press(K_IZQ);
        press(K_IZQ);
        ex(CUR, 6);
        press(K_ARR);
        ex(EC, 8'h00);
        press(K_MODE);
        ex(P_DIR, 8'h00); ex(CUR, 0); ex(WRQ, 0); ex(ALM, 1);

        press(K_MODE);
        press(K_MODE);
        press(K_MODE);
        press(K_ENT);
        ex(WRQ, 1); ex(WRD, 8'h04); ex(P_DIR, 8'h04);
        @(posedge clk);
        #2;
        rst = 1;
        #1;
        n_checks++;
        if (wr_req !== 1'b0 || progra_dir !== 8'h00) begin
            n_fail++;
            $display("FAIL async reset wr_req=%b progra_dir=%h", wr_req, progra_dir);
        end
        ex(WRQ, 0); ex(P_DIR, 8'h00); ex(CUR, 0); ex(WRD, 8'h00); ex(EA, 8'h00); ex(ALM, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        ack_pulse();
        ex(WRQ, 0); ex(P_DIR, 8'h00);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
